// File: rtl/cpu_instr_loader.sv
// Boot loader: unpacks a length-prefixed little-endian byte stream into 32-bit
// instruction memory writes and keeps the CPU in reset until the image is in.
module cpu_instr_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wrt_en,
    output logic [15:0] wrt_addr,
    output logic [31:0] wrt_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        err
);
    typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;

    localparam logic [18:0] LIMIT = 19'(MEM_BYTES);

    state_t      state;
    logic [15:0] n;
    logic [15:0] wcnt;
    logic [1:0]  lane;
    logic [23:0] pend;
    logic        last;
    logic        acc;
    logic [15:0] n_full;
    logic [18:0] end_addr;

    assign acc      = in_valid && in_ready;
    assign n_full   = {in_data, n[7:0]};
    // Widened so a large N can never wrap back under the limit.
    assign end_addr = {3'b000, BASE_ADDR} + {1'b0, n_full, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR0;
            in_ready  <= 1'b0;
            wrt_en    <= 1'b0;
            wrt_addr  <= BASE_ADDR;
            wrt_data  <= 32'h0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            err       <= 1'b0;
            n         <= 16'h0;
            wcnt      <= 16'h0;
            lane      <= 2'd0;
            pend      <= 24'h0;
            last      <= 1'b0;
        end else begin
            wrt_en <= 1'b0;
            case (state)
                HDR0: begin
                    in_ready <= 1'b1;
                    if (acc) begin
                        n[7:0] <= in_data;
                        state  <= HDR1;
                    end
                end
                HDR1: if (acc) begin
                    n <= n_full;
                    if (n_full == 16'h0) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                    end else if (end_addr > LIMIT) begin
                        state    <= ERR;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        state <= DATA;
                        lane  <= 2'd0;
                        wcnt  <= 16'h0;
                    end
                end
                DATA: begin
                    // in_ready was dropped with the final byte, so the last
                    // write cycle cannot swallow bytes of a following image.
                    if (last) begin
                        state     <= DONE;
                        last      <= 1'b0;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else if (acc) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: pend[7:0]   <= in_data;
                            2'd1: pend[15:8]  <= in_data;
                            2'd2: pend[23:16] <= in_data;
                            default: begin
                                wrt_en   <= 1'b1;
                                wrt_data <= {in_data, pend};
                                wrt_addr <= BASE_ADDR + {wcnt[13:0], 2'b00};
                                wcnt     <= wcnt + 16'd1;
                                if (wcnt == n - 16'd1) begin
                                    last     <= 1'b1;
                                    in_ready <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                DONE: begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                    if (start) begin
                        state     <= HDR0;
                        load_done <= 1'b0;
                        cpu_hold  <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ERR: if (start) begin
                    state    <= HDR0;
                    err      <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= HDR0;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_instr_loader.sv
// Randomized and directed bench for cpu_instr_loader against a byte-stream
// model that predicts every memory write from the accepted bytes.
module tb_cpu_instr_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, wrt_en, cpu_hold, load_done, err;
    logic [15:0] wrt_addr;
    logic [31:0] wrt_data;

    int errs = 0;
    int checks = 0;

    cpu_instr_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wrt_en(wrt_en), .wrt_addr(wrt_addr), .wrt_data(wrt_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    // model: byte index since header start, expected write queue
    int          m_idx = 0;
    logic [31:0] m_word;
    logic [15:0] m_n;
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [15:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_idx = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        int k;
        if (m_idx == 0) m_n[7:0] = b;
        else if (m_idx == 1) m_n[15:8] = b;
        else begin
            k = m_idx - 2;
            m_word[(k % 4) * 8 +: 8] = b;
            if (k % 4 == 3) begin
                exp_addr.push_back(16'(4 * (k / 4)));
                exp_data.push_back(m_word);
            end
        end
        m_idx++;
    endfunction

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!in_ready) begin
            errs++;
            $display("FAIL accept_timeout: in_ready stuck at %0b expected 1", in_ready);
        end else model_accept(b);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_reset();
    endtask

    // compare process: every write against the model, hold rules otherwise
    logic        hold_ok = 1'b0;
    logic [15:0] pa;
    logic [31:0] pd;
    always @(negedge clk) begin
        if (rst) hold_ok <= 1'b0;
        else begin
            if (wrt_en) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errs++;
                    $display("FAIL spurious_write: addr 0x%0h data 0x%0h expected no write", wrt_addr, wrt_data);
                end else begin
                    check("wr_addr", 32'(wrt_addr), 32'(exp_addr.pop_front()));
                    check("wr_data", wrt_data, exp_data.pop_front());
                end
                log_addr.push_back(wrt_addr);
                log_data.push_back(wrt_data);
            end else if (hold_ok) begin
                check("addr_hold", 32'(wrt_addr), 32'(pa));
                check("data_hold", wrt_data, pd);
            end
            check("addr_align", 32'(wrt_addr[1:0]), 32'd0);
            check("hold_vs_done", 32'(cpu_hold), 32'(!load_done));
            pa = wrt_addr;
            pd = wrt_data;
            hold_ok <= 1'b1;
        end
    end

    initial begin
        logic [7:0] img1 [10];
        img1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wrt_en", 32'(wrt_en), 0);
        check("rst_addr", 32'(wrt_addr), 0);
        check("rst_data", wrt_data, 0);
        check("rst_hold", 32'(cpu_hold), 1);
        check("rst_done", 32'(load_done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 1);

        // two-word image, in_valid held high
        for (int i = 0; i < 10; i++) send_byte(img1[i]);
        check("t1_wrt_en_latency", 32'(wrt_en), 1);
        check("t1_ready_low", 32'(in_ready), 0);
        @(negedge clk);
        check("t1_done", 32'(load_done), 1);
        check("t1_hold", 32'(cpu_hold), 0);
        check("t1_nwrites", log_addr.size(), 2);
        check("t1_a0", 32'(log_addr[0]), 32'h0000);
        check("t1_d0", log_data[0], 32'h01000013);
        check("t1_a1", 32'(log_addr[1]), 32'h0004);
        check("t1_d1", log_data[1], 32'h11223344);
        in_valid = 1'b0;
        @(negedge clk);

        // empty image
        pulse_start();
        check("t2_ready", 32'(in_ready), 1);
        check("t2_done_clr", 32'(load_done), 0);
        check("t2_hold_set", 32'(cpu_hold), 1);
        log_addr.delete();
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        check("t2_done", 32'(load_done), 1);
        check("t2_ready_low", 32'(in_ready), 0);
        check("t2_nwrites", log_addr.size(), 0);

        // oversize image N=16385
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h40);
        repeat (5) @(negedge clk);
        check("t3_err", 32'(err), 1);
        check("t3_ready", 32'(in_ready), 0);
        check("t3_hold", 32'(cpu_hold), 1);
        check("t3_nwrites", log_addr.size(), 0);
        pulse_start();
        check("t3_err_clr", 32'(err), 0);
        check("t3_ready_back", 32'(in_ready), 1);

        // reset mid-load, then a fresh 1-word image
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        exp_addr.delete();
        exp_data.delete();
        check("t4_rst_addr", 32'(wrt_addr), 0);
        check("t4_rst_data", wrt_data, 0);
        check("t4_rst_ready", 32'(in_ready), 0);
        check("t4_rst_hold", 32'(cpu_hold), 1);
        rst = 1'b0;
        @(negedge clk);
        log_addr.delete();
        log_data.delete();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_done", 32'(load_done), 1);
        check("t4_a0", 32'(log_addr[0]), 32'h0000);
        check("t4_d0", log_data[0], 32'hDDCCBBAA);

        // DONE ignores the host link
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_ready_low", 32'(in_ready), 0);
        end
        check("t5_nwrites", log_addr.size(), 1);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_done", 32'(load_done), 1);
        check("t5_nwrites2", log_addr.size(), 2);

        // full memory: N=16384, random bytes with random gaps
        pulse_start();
        log_addr.delete();
        log_data.delete();
        send_byte(8'h00);
        send_byte(8'h40);
        for (int i = 0; i < 65536; i++) begin
            send_byte(8'($urandom));
            if ($urandom_range(31) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_done", 32'(load_done), 1);
        check("t6_hold", 32'(cpu_hold), 0);
        check("t6_nwrites", log_addr.size(), 16384);
        if (log_addr.size() > 0) check("t6_last_addr", 32'(log_addr[log_addr.size() - 1]), 32'hFFFC);
        check("t6_exp_empty", exp_addr.size(), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
